tagged_scrub_array: RTL and testbench

TAGGED_SCRUB_ARRAY -- requirements
Module: tagged_scrub_array

---
 rtl/tagged_scrub_array.sv | 164 ++++++++++++++++
 tb/tb_tagged_scrub_array.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_scrub_array.sv
// Tagged storage array with a background scrub that zeroes every high-tagged entry.
// Optional build macro: TAGGED_SCRUB_READ_MASK_EN (masks high entries from low-cleared readers).
module tagged_scrub_array #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_tag,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_idx,
    input  logic             rd_priv,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_tag,
    output logic             rd_denied,
    input  logic             scrub_req,
    output logic             scrub_busy,
    output logic             scrub_done,
    output logic [AW:0]      hi_count
);

    // state    | meaning
    // ST_IDLE  | accepting writes, waiting for scrub_req
    // ST_SCRUB | visiting entry ptr each cycle, clearing it if high
    // ST_DONE  | one-cycle completion pulse, then back to idle
    typedef enum logic [1:0] {ST_IDLE, ST_SCRUB, ST_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] tag;
    logic [AW-1:0]    ptr;

    logic wr_acc;
    logic scrub_start;
    logic scrub_hit;
    logic scrub_last;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_acc      = wr_en & wr_ready;
    assign scrub_start = (state == ST_IDLE) & scrub_req;
    assign scrub_hit   = (state == ST_SCRUB) & tag[ptr];
    assign scrub_last  = (ptr == AW'(DEPTH - 1));

    // Writes and scrub visits never share a cycle, so at most one tag changes per edge.
    assign cnt_inc = wr_acc & ~tag[wr_idx] & wr_tag;
    assign cnt_dec = (wr_acc & tag[wr_idx] & ~wr_tag) | scrub_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (scrub_req) state_nxt = ST_SCRUB;
            ST_SCRUB: if (scrub_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready   = 1'b0;
        scrub_busy = 1'b0;
        scrub_done = 1'b0;
        case (state)
            ST_IDLE:  wr_ready = 1'b1;
            ST_SCRUB: scrub_busy = 1'b1;
            ST_DONE: begin
                scrub_busy = 1'b1;
                scrub_done = 1'b1;
            end
            default:  wr_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (scrub_start) begin
            ptr <= '0;
        end else if (state == ST_SCRUB) begin
            ptr <= ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tag <= '0;
        end else if (wr_acc) begin
            mem[wr_idx] <= wr_data;
            tag[wr_idx] <= wr_tag;
        end else if (scrub_hit) begin
            mem[ptr] <= '0;
            tag[ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_count <= '0;
        end else if (cnt_inc) begin
            hi_count <= hi_count + (AW + 1)'(1);
        end else if (cnt_dec) begin
            hi_count <= hi_count - (AW + 1)'(1);
        end
    end

    // Read port samples the array before this edge's write, giving read-before-write.
`ifdef TAGGED_SCRUB_READ_MASK_EN
    logic deny;
    assign deny = tag[rd_idx] & ~rd_priv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_tag    <= 1'b0;
            rd_denied <= 1'b0;
        end else if (rd_en) begin
            rd_valid  <= 1'b1;
            rd_data   <= deny ? '0 : mem[rd_idx];
            rd_tag    <= tag[rd_idx];
            rd_denied <= deny;
        end else begin
            rd_valid  <= 1'b0;
        end
    end
`else
    logic unused_rd_priv;
    assign unused_rd_priv = rd_priv;
    assign rd_denied      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_tag   <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_idx];
            rd_tag   <= tag[rd_idx];
        end else begin
            rd_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tagged_scrub_array.sv
// Scoreboard bench for tagged_scrub_array (WIDTH=8, DEPTH=16): directed scenarios then random traffic.
module tb_tagged_scrub_array;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef TAGGED_SCRUB_READ_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_tag;
    logic             wr_ready;
    logic             rd_en;
    logic [AW-1:0]    rd_idx;
    logic             rd_priv;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_tag;
    logic             rd_denied;
    logic             scrub_req;
    logic             scrub_busy;
    logic             scrub_done;
    logic [AW:0]      hi_count;

    tagged_scrub_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_tag(wr_tag), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_priv(rd_priv),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag), .rd_denied(rd_denied),
        .scrub_req(scrub_req), .scrub_busy(scrub_busy), .scrub_done(scrub_done), .hi_count(hi_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             t;
        logic             dn;
    } rd_exp_t;

    rd_exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: contents plus remaining cycles of an in-flight scrub (0 = idle).
    logic [WIDTH-1:0] m_data [DEPTH];
    logic             m_tag  [DEPTH];
    int               m_left = 0;
    int               m_vis  = 0;

    logic [WIDTH-1:0] last_d  = '0;
    logic             last_t  = 1'b0;
    logic             last_dn = 1'b0;
    int               busy_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_hi();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_tag[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_tag[i]  = 1'b0;
        end
        m_left = 0;
        m_vis  = 0;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_idx = '0; wr_data = '0; wr_tag = 0;
        rd_en = 0; rd_idx = '0; rd_priv = 0; scrub_req = 0;
    endtask

    task automatic step(input logic we, input int wi, input logic [WIDTH-1:0] wd, input logic wt,
                        input logic re, input int ri, input logic rp, input logic sr);
        rd_exp_t e;
        @(negedge clk);
        chk("wr_ready",   wr_ready,   m_left == 0);
        chk("scrub_busy", scrub_busy, m_left != 0);
        chk("scrub_done", scrub_done, m_left == 1);
        chk("hi_count",   hi_count,   model_hi());
        wr_en = we; wr_idx = AW'(wi); wr_data = wd; wr_tag = wt;
        rd_en = re; rd_idx = AW'(ri); rd_priv = rp; scrub_req = sr;
        if (re) begin
            if (MASK && m_tag[ri] && !rp) begin
                e.d = '0; e.t = 1'b1; e.dn = 1'b1;
            end else begin
                e.d = m_data[ri]; e.t = m_tag[ri]; e.dn = 1'b0;
            end
            q.push_back(e);
        end
        @(posedge clk);
        if (m_left == 0) begin
            if (we) begin
                m_data[wi] = wd;
                m_tag[wi]  = wt;
            end
            if (sr) begin
                m_left = DEPTH + 1;
                m_vis  = 0;
            end
        end else begin
            if (m_left > 1) begin
                if (m_tag[m_vis]) begin
                    m_data[m_vis] = '0;
                    m_tag[m_vis]  = 1'b0;
                end
                m_vis++;
            end
            m_left--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int idx, input logic [WIDTH-1:0] d, input logic t);
        step(1, idx, d, t, 0, 0, 0, 0);
    endtask

    task automatic rd(input int idx, input logic p);
        step(0, 0, '0, 0, 1, idx, p, 0);
    endtask

    // Called just after a posedge: reset lands mid-cycle, outputs must clear at once.
    task automatic async_reset();
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_rd_valid",   rd_valid,   0);
        chk("rst_rd_data",    rd_data,    0);
        chk("rst_rd_tag",     rd_tag,     0);
        chk("rst_rd_denied",  rd_denied,  0);
        chk("rst_scrub_busy", scrub_busy, 0);
        chk("rst_scrub_done", scrub_done, 0);
        chk("rst_hi_count",   hi_count,   0);
        model_clear();
        q.delete();
        last_d = '0; last_t = 1'b0; last_dn = 1'b0;
        busy_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = q.pop_front();
                    chk("rd_data",   rd_data,   e.d);
                    chk("rd_tag",    rd_tag,    e.t);
                    chk("rd_denied", rd_denied, e.dn);
                    last_d = e.d; last_t = e.t; last_dn = e.dn;
                end
            end else begin
                chk("rd_hold_data",   rd_data,   last_d);
                chk("rd_hold_tag",    rd_tag,    last_t);
                chk("rd_hold_denied", rd_denied, last_dn);
            end
            if (scrub_done) chk("hi_at_done", hi_count, 0);
            if (scrub_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_length", busy_run, DEPTH + 1);
                busy_run = 0;
            end
        end
    end

    initial begin
        int guard;
        model_clear();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk("init_rd_valid", rd_valid, 0);
        chk("init_hi_count", hi_count, 0);
        chk("init_busy",     scrub_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Tagged write then privileged and unprivileged reads.
        wr(3, 8'h5A, 1);
        rd(3, 1);
        rd(3, 0);
        idle(2);

        // Scrub clears high entries only.
        wr(0, 8'hC3, 1);
        wr(7, 8'h77, 1);
        wr(15, 8'hF0, 1);
        wr(4, 8'h11, 0);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2) step(1, 2, 8'hEE, 1, 1, 7, 1, 0);
            else        step(0, 0, '0, 0, 1, i, 1, 0);
        end
        step(0, 0, '0, 0, 0, 0, 0, 1);
        idle(3);
        rd(4, 1);
        rd(7, 1);
        rd(2, 1);
        rd(3, 1);

        // Same-cycle read and write.
        wr(5, 8'h22, 0);
        step(1, 5, 8'h33, 0, 1, 5, 1, 0);
        rd(5, 1);
        idle(2);

        // Reset mid-scrub at ptr = 8.
        wr(12, 8'hAB, 1);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        guard = 0;
        while (m_vis < 8 && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("reach_ptr8", m_vis, 8);
        async_reset();
        idle(1);
        rd(12, 1);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), WIDTH'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 1), $urandom_range(0, 19) == 0);
        end
        idle(DEPTH + 4);
        chk("rd_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
